csd_convert_seq: RTL

CSD_CONVERT_SEQ -- requirements
Module: csd_convert_seq

---
 rtl/csd_convert_seq.sv | 118 +++++++++++
 1 files changed

// File: rtl/csd_convert_seq.sv
// Sequential binary-to-canonical-signed-digit (non-adjacent form) converter.
// Produces one CSD digit per clock and stops early once the residue reaches zero.
module csd_convert_seq #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   pos,
  output logic [WIDTH:0]   neg,
  output logic [CW-1:0]    nz_cnt,
  output logic             sign
);

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

  localparam logic [WIDTH:0] ONE_V = {{WIDTH{1'b0}}, 1'b1};

  state_t          state, state_nx;
  logic [WIDTH:0]  v;
  logic [CW-1:0]   idx;
  logic [WIDTH:0]  v_upd;
  logic [WIDTH:0]  bit_m;
  logic            plus_d, minus_d, wr_p, wr_n;
  logic            v_zero, idx_end;

  // Magnitude of the operand; the most negative value maps to 2^(WIDTH-1),
  // which still fits because the result carries one extra bit.
  function automatic logic [WIDTH:0] mag_f(input logic [WIDTH-1:0] d, input logic s);
    logic [WIDTH-1:0] n;
    n = (~d) + WIDTH'(1);
    return (s && d[WIDTH-1]) ? {1'b0, n} : {1'b0, d};
  endfunction

  assign v_zero  = (v == '0);
  assign idx_end = (idx == CW'(WIDTH + 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = STEP;
      end
      STEP: if (v_zero || idx_end) state_nx = DONE;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Digit selection: odd residues take the digit that leaves a multiple of 4,
  // which is what guarantees no two adjacent nonzero digits.
  always_comb begin
    v_upd   = v;
    plus_d  = 1'b0;
    minus_d = 1'b0;
    case (v[1:0])
      2'b01: begin
        plus_d = 1'b1;
        v_upd  = v - ONE_V;
      end
      2'b11: begin
        minus_d = 1'b1;
        v_upd   = v + ONE_V;
      end
      default: ;
    endcase
    wr_p  = sign ? minus_d : plus_d;
    wr_n  = sign ? plus_d : minus_d;
    bit_m = ONE_V << idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v      <= '0;
      idx    <= '0;
      pos    <= '0;
      neg    <= '0;
      nz_cnt <= '0;
      sign   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          v      <= mag_f(din, signed_mode);
          sign   <= signed_mode & din[WIDTH-1];
          idx    <= '0;
          pos    <= '0;
          neg    <= '0;
          nz_cnt <= '0;
        end
        STEP: if (!v_zero && !idx_end) begin
          v   <= v_upd >> 1;
          idx <= idx + CW'(1);
          if (wr_p) pos <= pos | bit_m;
          if (wr_n) neg <= neg | bit_m;
          if (plus_d || minus_d) nz_cnt <= nz_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
